// File: rtl/serial_frame_receiver_pkg.sv
// Shared definitions for the serial frame receiver: FSM encodings, idle line
// level and the bit-counter width derivation.
package serial_frame_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  // Upstream register resets to all ones, so an idle line reads as 1.
  localparam logic IDLE_LVL = 1'b1;

  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Serial input / word output bundle between the upstream stage, the receiver
// and the downstream consumer.
interface serial_frame_receiver_if #(
  parameter int WIDTH = 8
);
  logic             CE;
  logic             SI;
  logic [WIDTH-1:0] DO;
  logic             DV;
  logic             DR;
  logic             FERR;
  logic             OVF;

  modport master (output CE, SI, DR, input DO, DV, FERR, OVF);
  modport slave  (input CE, SI, DR, output DO, DV, FERR, OVF);
endinterface

// File: rtl/serial_frame_holdreg.sv
// One-entry output buffer: loads a finished word, releases it on DV&DR, and
// flags a sticky overflow when a word arrives while the entry is still held.
module serial_frame_holdreg #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_rdy,
  output logic [WIDTH-1:0] o_data,
  output logic             o_vld,
  output logic             o_ovf
);
  logic [WIDTH-1:0] r_data;
  logic             r_vld;
  logic             r_ovf;
  logic             w_room;

  // Entry is free this edge if empty or being consumed right now.
  assign w_room = !r_vld || i_rdy;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
      r_vld  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (i_load && w_room) begin
        r_data <= i_data;
        r_vld  <= 1'b1;
      end else if (r_vld && i_rdy) begin
        r_vld  <= 1'b0;
      end
      if (i_load && !w_room)
        r_ovf <= 1'b1;
    end
  end

  assign o_data = r_data;
  assign o_vld  = r_vld;
  assign o_ovf  = r_ovf;
endmodule

// File: rtl/serial_frame_receiver.sv
// Start/stop framed serial receiver: MSB-first reassembly of WIDTH-bit words
// into a one-entry valid/ready output buffer.
module serial_frame_receiver
  import serial_frame_receiver_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                   C,
  input logic                   R,
  serial_frame_receiver_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic             r_ferr;

  logic             w_load;
  logic [WIDTH-1:0] w_do;
  logic             w_dv;
  logic             w_ovf;

  always_ff @(posedge C) begin
    if (R) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_ferr  <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      if (bus.CE) begin
        case (r_state)
          ST_IDLE: begin
            if (bus.SI != IDLE_LVL) begin
              r_state <= ST_DATA;
              r_cnt   <= '0;
            end
          end
          ST_DATA: begin
            r_shreg <= {r_shreg[WIDTH-2:0], bus.SI};
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == CW'(WIDTH-1))
              r_state <= ST_STOP;
          end
          ST_STOP: begin
            // A 0 here is a framing error, never a new start bit.
            if (!bus.SI)
              r_ferr <= 1'b1;
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign w_load = bus.CE && (r_state == ST_STOP) && bus.SI;

  serial_frame_holdreg #(.WIDTH(WIDTH)) u_hold (
    .i_clk  (C),
    .i_rst  (R),
    .i_load (w_load),
    .i_data (r_shreg),
    .i_rdy  (bus.DR),
    .o_data (w_do),
    .o_vld  (w_dv),
    .o_ovf  (w_ovf)
  );

  assign bus.DO   = w_do;
  assign bus.DV   = w_dv;
  assign bus.FERR = r_ferr;
  assign bus.OVF  = w_ovf;
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver: frame table plus hand-written
// overflow, consume/load, CE gating and mid-frame reset sequences.
module tb_serial_frame_receiver;
  localparam int W = 8;

  logic C;
  logic R;
  int   tests;
  int   fails;

  serial_frame_receiver_if #(.WIDTH(W)) bus ();

  serial_frame_receiver #(.WIDTH(W)) dut (
    .C   (C),
    .R   (R),
    .bus (bus)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  typedef struct {
    string        name;
    logic [W-1:0] data;
    logic         stop;
    logic         dr;
    logic [W-1:0] exp_do;
    logic         exp_dv;
    logic         exp_ferr;
    logic         exp_ovf;
    logic         idle;
    logic         exp_dv_after;
    logic         exp_ferr_after;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [W-1:0] d, input logic dv,
                         input logic ferr, input logic ovf);
    chk({name, ".DO"},   32'(bus.DO),   32'(d));
    chk({name, ".DV"},   32'(bus.DV),   32'(dv));
    chk({name, ".FERR"}, 32'(bus.FERR), 32'(ferr));
    chk({name, ".OVF"},  32'(bus.OVF),  32'(ovf));
  endtask

  task automatic do_reset();
    R = 1'b1; bus.CE = 1'b1; bus.SI = 1'b1;
    tick();
    R = 1'b0;
  endtask

  // Sends start, data MSB first, stop; with gap, a CE=0 cycle carrying a
  // misleading SI value precedes every bit.
  task automatic send_frame(input logic [W-1:0] d, input logic stop, input logic dr,
                            input logic dr_stop, input logic gap);
    logic [W+1:0] bits;
    bits = {1'b0, d, stop};
    for (int i = W + 1; i >= 0; i--) begin
      if (gap) begin
        bus.CE = 1'b0;
        bus.SI = (i == W + 1) ? 1'b0 : ~bits[i];
        bus.DR = dr;
        tick();
      end
      bus.CE = 1'b1;
      bus.SI = bits[i];
      bus.DR = (i == 0) ? dr_stop : dr;
      tick();
    end
    bus.SI = 1'b1;
    bus.DR = dr;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    R = 1'b1; bus.CE = 1'b0; bus.SI = 1'b1; bus.DR = 1'b0;
    tick(); tick();
    R = 1'b0;
    chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);

    vecs[0] = '{"a5",      8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{"bad3c_b2b", 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{"81_after", 8'h81, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{"bad3c",   8'h3C, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{"81_clean", 8'h81, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    for (int k = 0; k < 5; k++) begin
      send_frame(vecs[k].data, vecs[k].stop, vecs[k].dr, vecs[k].dr, 1'b0);
      chk_out(vecs[k].name, vecs[k].exp_do, vecs[k].exp_dv, vecs[k].exp_ferr, vecs[k].exp_ovf);
      if (vecs[k].idle) begin
        bus.CE = 1'b1; bus.SI = 1'b1; bus.DR = vecs[k].dr;
        tick();
        chk({vecs[k].name, ".DV_after"},   32'(bus.DV),   32'(vecs[k].exp_dv_after));
        chk({vecs[k].name, ".FERR_after"}, 32'(bus.FERR), 32'(vecs[k].exp_ferr_after));
      end
    end

    // Overflow: second word dropped while first is held.
    do_reset();
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_out("ovf_first", 8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_out("ovf_second", 8'h11, 1'b1, 1'b0, 1'b1);
    bus.DR = 1'b1;
    tick();
    chk_out("ovf_drain", 8'h11, 1'b0, 1'b0, 1'b1);

    // Consume and load on the same edge.
    do_reset();
    send_frame(8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_out("sim_hold", 8'h33, 1'b1, 1'b0, 1'b0);
    send_frame(8'h44, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_out("sim_load", 8'h44, 1'b1, 1'b0, 1'b0);
    bus.DR = 1'b0;
    tick();
    chk("sim_keep.DV", 32'(bus.DV), 32'd1);

    // CE gating with misleading SI on every CE=0 cycle.
    do_reset();
    send_frame(8'hC3, 1'b1, 1'b1, 1'b1, 1'b1);
    chk_out("ce_gate", 8'hC3, 1'b1, 1'b0, 1'b0);

    // Reset after start + 4 data bits, then a clean 0x5A.
    bus.CE = 1'b1; bus.DR = 1'b1;
    bus.SI = 1'b0; tick();
    bus.SI = 1'b1; tick();
    bus.SI = 1'b1; tick();
    bus.SI = 1'b0; tick();
    bus.SI = 1'b0; tick();
    R = 1'b1; bus.SI = 1'b1;
    tick();
    R = 1'b0;
    chk_out("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    chk("mid_idle.DV", 32'(bus.DV), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
    chk_out("after_reset", 8'h5A, 1'b1, 1'b0, 1'b0);
    tick();
    chk("after_reset.DV_after", 32'(bus.DV), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
